// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the flash read arbiter and its requesters.
package flash_arb_pkg;

  localparam int unsigned FLASH_LATENCY = 11;
  localparam int unsigned CNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_NET  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear, enable and programmable rollover.
module flex_counter #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out
);

  logic [NUM_CNT_BITS-1:0] count_d;

  always_comb begin
    count_d = count_out;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_out == rollover_val) count_d = NUM_CNT_BITS'(1);
      else                           count_d = count_out + NUM_CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_out <= '0;
    else        count_out <= count_d;
  end

endmodule

// File: rtl/flash_read_arbiter.sv
// Arbitrates net/host reads onto the single flash port with a req/done handshake.
// Define FLASH_ARB_FIXED_PRI_EN for fixed net priority instead of round-robin.
module flash_read_arbiter
  import flash_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned LATENCY = FLASH_LATENCY
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              net_req,
  input  logic [ADDR_W-1:0] net_addr,
  output logic              net_done,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              flash_ready,
  output logic [ADDR_W-1:0] flash_address,
  input  logic [DATA_W-1:0] flashData_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ROLL = CNT_W'(LATENCY);

  arb_state_t        state, next_state;
  owner_t            owner, owner_d, pick_c;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] rdata_d;
  logic              cnt_clear, cnt_en;
  logic [CNT_W-1:0]  count;

  flex_counter #(
    .NUM_CNT_BITS (CNT_W)
  ) u_lat_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (cnt_en),
    .rollover_val (CNT_ROLL),
    .count_out    (count)
  );

`ifdef FLASH_ARB_FIXED_PRI_EN
  // Net always wins; host only gets the port when net is idle.
  always_comb pick_c = net_req ? OWN_NET : OWN_HOST;
`else
  owner_t last_grant;

  always_comb begin
    pick_c = net_req ? OWN_NET : OWN_HOST;
    if (net_req && host_req) pick_c = (last_grant == OWN_NET) ? OWN_HOST : OWN_NET;
  end

  // Reset to host so net wins the first tie.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)             last_grant <= OWN_HOST;
    else if (state == DONE) last_grant <= owner;
  end
`endif

  always_comb begin
    next_state = state;
    owner_d    = owner;
    addr_d     = flash_address;
    rdata_d    = rdata;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      IDLE: begin
        if (net_req || host_req) begin
          owner_d    = pick_c;
          addr_d     = (pick_c == OWN_NET) ? net_addr : host_addr;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        cnt_clear  = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        cnt_en = 1'b1;
        if (count == CNT_LAST) begin
          rdata_d    = flashData_out;
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      owner         <= OWN_NET;
      flash_address <= '0;
      rdata         <= '0;
      flash_ready   <= 1'b0;
      busy          <= 1'b0;
      net_done      <= 1'b0;
      host_done     <= 1'b0;
    end else begin
      state         <= next_state;
      owner         <= owner_d;
      flash_address <= addr_d;
      rdata         <= rdata_d;
      flash_ready   <= (next_state == ISSUE);
      busy          <= (next_state != IDLE);
      net_done      <= (next_state == DONE) && (owner_d == OWN_NET);
      host_done     <= (next_state == DONE) && (owner_d == OWN_HOST);
    end
  end

endmodule

// File: doc/flash_read_arbiter.md
Name: flash_read_arbiter

Overview:
- Shares the single flash weight/bias memory between two requesters: the network controller (req 0, weight/bias fetch) and the host/SPI loader port (req 1, readback/debug).
- Replaces ad-hoc fixed wait counting in requesters with a req/done handshake.
- Sits between the requesters and the flash model/controller, which takes a one-cycle read strobe and an address, and returns data LATENCY cycles later.

Parameters:
- ADDR_W, 16, flash address width
- DATA_W, 16, flash data width
- LATENCY, 11, cycles from strobe to valid flashData_out; legal range 1..15

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- net_req  in  1  network controller read request, level, held until net_done
- net_addr  in  ADDR_W  network read address, sampled at grant
- net_done  out  1  one-cycle pulse; rdata valid for net read
- host_req  in  1  host read request, level, held until host_done
- host_addr  in  ADDR_W  host read address, sampled at grant
- host_done  out  1  one-cycle pulse; rdata valid for host read
- rdata  out  DATA_W  registered read data, held until next capture
- busy  out  1  high in any state other than IDLE
- flash_ready  out  1  one-cycle read strobe to flash
- flash_address  out  ADDR_W  registered read address, stable from ISSUE through DONE
- flashData_out  in  DATA_W  flash read data

Behaviour:
- Reset values: all outputs 0; state IDLE; count 0; last_grant = host, so net wins the first tie.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

State machine, with states IDLE, ISSUE, WAIT, DONE:
- IDLE: if any req is high, choose a winner, latch owner and address into flash_address, go to ISSUE. Otherwise stay.
- ISSUE: flash_ready=1 for exactly this cycle. Clear count. Go to WAIT.
- WAIT: count increments each cycle. When count == LATENCY-1, capture flashData_out into rdata and go to DONE.
- DONE: assert the owner's done (net_done or host_done) for one cycle. Update last_grant to owner. Go to IDLE.

Timing:
- Request seen high at clock edge k produces done high during cycle k+LATENCY+2.
- Minimum spacing between strobes is LATENCY+3 cycles.

Arbitration (round-robin):
- Single requester: it is granted.
- Both requesting: the one that is not last_grant wins.

Handshake rules:
- A requester drops req in the cycle done is high, or re-arbitrates on the following IDLE.
- A req deasserted after grant does not abort: the read completes and done still pulses.
- Address changes after grant are ignored.

Boundaries:
- LATENCY=1: WAIT lasts one cycle.
- Count width is 4 bits; it never wraps within legal LATENCY.
- n_rst asserted mid-WAIT: returns to IDLE immediately, no done is issued, rdata is cleared, flash_ready is 0.
- net_done and host_done are never high together.

Optional Feature:
- Macro FLASH_ARB_FIXED_PRI_EN.
- Defined: fixed priority. net always wins ties, last_grant is unused, and host can starve while net requests continuously.
- Undefined: round-robin as above.
- Port list is identical in both cases.

Decomposition:
- Shared package flash_arb_pkg holds:
  - the state typedef (IDLE, ISSUE, WAIT, DONE)
  - the owner typedef (OWN_NET, OWN_HOST)
  - the default LATENCY constant 11, for reuse by the network controller
- Latency timing uses the existing flex_counter sub-module (NUM_CNT_BITS=4, rollover_val=LATENCY), with clear driven in ISSUE and count_enable driven in WAIT.
- No other sub-module.

Test Plan:
- Single net read: net_req=1, net_addr=0x0005, flash returns 0xA5C3 -> flash_address=0x0005, flash_ready high 1 cycle, net_done pulses 13 cycles after the sampling edge, rdata=0xA5C3, host_done stays 0.
- Simultaneous requests after reset: net_addr=0x0010, host_addr=0x0020 -> net is served first with strobe at 0x0010, then host with strobe at 0x0020; strobes are 14 cycles apart.
- Fairness: both held high for 4 transactions -> grants alternate net, host, net, host. With FLASH_ARB_FIXED_PRI_EN, all 4 grants go to net.
- Reset mid-operation: n_rst pulsed low at WAIT count 5 -> no done pulse, rdata=0, busy=0, the next request is served normally with full latency.
- Req drop after grant: net_req lowered 1 cycle after ISSUE -> read still completes and net_done pulses once.
- LATENCY=1 build: single host read -> host_done pulses 3 cycles after the sampling edge, rdata matches flash data.
